// File: rtl/im_pkg.sv
// Shared types and constants for the im2 instruction memory: FSM states,
// reset values and the byte-offset width helper.
package im_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2
    } im_state_e;

    localparam im_state_e RST_STATE    = IDLE;
    localparam logic      RST_VALID    = 1'b0;
    localparam logic      RST_ERR      = 1'b0;
    localparam logic      RST_OVERFLOW = 1'b0;

    function automatic int byte_off_w(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/im2_rd_pipe.sv
// Fetch return pipeline: RD_LATENCY register stages carrying valid/err/data,
// plus an indication that nothing remains behind the output stage.
module im2_rd_pipe
    import im_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_err,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic                  out_err,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  empty
);

    logic [RD_LATENCY-1:0] valid_r;
    logic [RD_LATENCY-1:0] err_r;
    logic [DATA_WIDTH-1:0] data_r [RD_LATENCY];
    logic                  empty_s;

    // Shift register; stage 0 captures the array read, erroneous reads carry zero data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= {RD_LATENCY{RST_VALID}};
            err_r   <= {RD_LATENCY{RST_ERR}};
            for (int i = 0; i < RD_LATENCY; i++) begin
                data_r[i] <= '0;
            end
        end else begin
            valid_r[0] <= in_valid;
            err_r[0]   <= in_valid & in_err;
            data_r[0]  <= (in_valid && !in_err) ? in_data : '0;
            for (int i = 1; i < RD_LATENCY; i++) begin
                valid_r[i] <= valid_r[i-1];
                err_r[i]   <= err_r[i-1];
                data_r[i]  <= data_r[i-1];
            end
        end
    end

    // Only the output stage may still be valid: the last return issues this cycle
    always_comb begin
        empty_s = 1'b1;
        for (int i = 0; i < RD_LATENCY - 1; i++) begin
            if (valid_r[i]) begin
                empty_s = 1'b0;
            end else begin
                empty_s = empty_s;
            end
        end
    end

    assign out_valid = valid_r[RD_LATENCY-1];
    assign out_err   = err_r[RD_LATENCY-1];
    assign out_data  = data_r[RD_LATENCY-1];
    assign empty     = empty_s;

endmodule

// File: rtl/im2_fetch_mem.sv
// Instruction memory with a pipelined fetch port and a burst program-load port
// sharing one array; the FSM drains fetches before granting the loader access.
module im2_fetch_mem
    import im_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int RD_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fetch_req,
    input  logic [ADDR_WIDTH-1:0]     fetch_addr,
    output logic                      fetch_ready,
    output logic                      fetch_valid,
    output logic [DATA_WIDTH-1:0]     fetch_data,
    output logic                      fetch_err,
    input  logic                      ld_start,
    input  logic [ADDR_WIDTH-1:0]     ld_base,
    input  logic                      ld_valid,
    input  logic [DATA_WIDTH-1:0]     ld_data,
    input  logic [DATA_WIDTH/8-1:0]   ld_strb,
    input  logic                      ld_last,
    output logic                      ld_ready,
    output logic                      ld_busy,
    output logic                      ld_overflow,
    output logic [$clog2(DEPTH):0]    ld_count
);

    localparam int OFF_W  = byte_off_w(DATA_WIDTH);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int CNT_W  = IDX_W + 1;
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    im_state_e             state_r;
    im_state_e             state_s;
    logic [ADDR_WIDTH-1:0] ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  ovf_r;

    logic [ADDR_WIDTH-1:0] fetch_idx_s;
    logic                  fetch_bad_s;
    logic                  fetch_acc_s;
    logic [DATA_WIDTH-1:0] rd_data_s;
    logic                  beat_s;
    logic                  wr_en_s;
    logic                  pipe_empty_s;

    assign fetch_idx_s = fetch_addr >> OFF_W;
    assign fetch_bad_s = (|(fetch_addr & OFF_MASK)) || (fetch_idx_s >= DEPTH_A);
    assign fetch_acc_s = fetch_req && fetch_ready;
    assign rd_data_s   = fetch_bad_s ? '0 : mem[fetch_idx_s[IDX_W-1:0]];
    assign beat_s      = (state_r == LOAD) && ld_valid;
    // Beats past the end of the array are counted but never written
    assign wr_en_s     = beat_s && (ptr_r < DEPTH_A);

    // Next-state and port handshakes
    always_comb begin
        state_s     = state_r;
        fetch_ready = 1'b0;
        ld_ready    = 1'b0;
        ld_busy     = 1'b1;
        case (state_r)
            IDLE: begin
                ld_busy     = 1'b0;
                fetch_ready = !ld_start;
                if (ld_start) begin
                    state_s = pipe_empty_s ? LOAD : DRAIN;
                end else begin
                    state_s = IDLE;
                end
            end
            DRAIN: begin
                if (pipe_empty_s) begin
                    state_s = LOAD;
                end else begin
                    state_s = DRAIN;
                end
            end
            LOAD: begin
                ld_ready = 1'b1;
                if (beat_s && ld_last) begin
                    state_s = IDLE;
                end else begin
                    state_s = LOAD;
                end
            end
            default: begin
                state_s = IDLE;
                ld_busy = 1'b0;
            end
        endcase
    end

    // FSM state, load pointer, beat counter and sticky overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= RST_STATE;
            ptr_r   <= '0;
            count_r <= '0;
            ovf_r   <= RST_OVERFLOW;
        end else begin
            state_r <= state_s;
            if ((state_r == IDLE) && ld_start) begin
                ptr_r   <= ld_base >> OFF_W;
                count_r <= '0;
                ovf_r   <= 1'b0;
            end else if (beat_s) begin
                ptr_r   <= ptr_r + ADDR_WIDTH'(1);
                count_r <= count_r + CNT_W'(1);
                ovf_r   <= ovf_r | !wr_en_s;
            end else begin
                ptr_r   <= ptr_r;
                count_r <= count_r;
                ovf_r   <= ovf_r;
            end
        end
    end

    // Array write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (ld_strb[b]) begin
                    mem[ptr_r[IDX_W-1:0]][b*8 +: 8] <= ld_data[b*8 +: 8];
                end
            end
        end
    end

    im2_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (fetch_acc_s),
        .in_err    (fetch_bad_s),
        .in_data   (rd_data_s),
        .out_valid (fetch_valid),
        .out_err   (fetch_err),
        .out_data  (fetch_data),
        .empty     (pipe_empty_s)
    );

    assign ld_overflow = ovf_r;
    assign ld_count    = count_r;

endmodule

// File: tb/tb_im2_fetch_mem.sv
// Directed bench: two instances (RD_LATENCY 2 and 4) share all inputs; each
// scenario task checks the instance whose latency it targets.
module tb_im2_fetch_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_addr = 32'd0;
    logic        ld_start = 1'b0;
    logic [31:0] ld_base = 32'd0;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_data = 32'd0;
    logic [3:0]  ld_strb = 4'd0;
    logic        ld_last = 1'b0;

    logic        f_ready2, f_valid2, f_err2, ld_ready2, ld_busy2, ld_ovf2;
    logic [31:0] f_data2;
    logic [8:0]  ld_cnt2;
    logic        f_ready4, f_valid4, f_err4, ld_ready4, ld_busy4, ld_ovf4;
    logic [31:0] f_data4;
    logic [8:0]  ld_cnt4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    im2_fetch_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(256), .RD_LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ready(f_ready2), .fetch_valid(f_valid2), .fetch_data(f_data2), .fetch_err(f_err2),
        .ld_start(ld_start), .ld_base(ld_base), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_strb(ld_strb), .ld_last(ld_last), .ld_ready(ld_ready2), .ld_busy(ld_busy2),
        .ld_overflow(ld_ovf2), .ld_count(ld_cnt2));

    im2_fetch_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(256), .RD_LATENCY(4)) dut4 (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ready(f_ready4), .fetch_valid(f_valid4), .fetch_data(f_data4), .fetch_err(f_err4),
        .ld_start(ld_start), .ld_base(ld_base), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_strb(ld_strb), .ld_last(ld_last), .ld_ready(ld_ready4), .ld_busy(ld_busy4),
        .ld_overflow(ld_ovf4), .ld_count(ld_cnt4));

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Burst from IDLE with empty pipes: one start cycle, then n back-to-back beats
    task automatic load_burst(input logic [31:0] base, input int n, input logic [31:0] d0,
                              input logic [31:0] d1, input logic [31:0] d2, input logic [3:0] s);
        ld_start = 1'b1; ld_base = base;
        step(1);
        ld_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            ld_valid = 1'b1; ld_strb = s; ld_last = (i == n - 1);
            ld_data = (i == 0) ? d0 : ((i == 1) ? d1 : d2);
            step(1);
        end
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        step(2);
        if (f_valid2 !== 1'b0) begin errors++; $display("FAIL rst_fetch_valid: got %b expected 0", f_valid2); end checks++;
        if (f_err4 !== 1'b0) begin errors++; $display("FAIL rst_fetch_err: got %b expected 0", f_err4); end checks++;
        if (f_data2 !== 32'd0) begin errors++; $display("FAIL rst_fetch_data: got %h expected 0", f_data2); end checks++;
        if ({ld_ready2, ld_busy2, ld_ovf2} !== 3'b000) begin errors++; $display("FAIL rst_ld_flags: got %b expected 000", {ld_ready2, ld_busy2, ld_ovf2}); end checks++;
        if (ld_cnt4 !== 9'd0) begin errors++; $display("FAIL rst_ld_count: got %0d expected 0", ld_cnt4); end checks++;
        rst = 1'b1;
        step(1);
        if ({f_ready2, f_ready4} !== 2'b11) begin errors++; $display("FAIL rst_fetch_ready: got %b expected 11", {f_ready2, f_ready4}); end checks++;
    endtask

    task automatic test_load_fetch;
        load_burst(32'h8, 2, 32'h12345678, 32'hAABBCCDD, 32'h0, 4'hF);
        if (ld_cnt2 !== 9'd2) begin errors++; $display("FAIL lf_count: got %0d expected 2", ld_cnt2); end checks++;
        if (ld_busy2 !== 1'b0) begin errors++; $display("FAIL lf_busy: got %b expected 0", ld_busy2); end checks++;
        fetch_req = 1'b1; fetch_addr = 32'h8;
        #1;
        if (f_ready2 !== 1'b1) begin errors++; $display("FAIL lf_ready: got %b expected 1", f_ready2); end checks++;
        step(1);
        fetch_addr = 32'hC;
        if (f_valid2 !== 1'b0) begin errors++; $display("FAIL lf_early_valid: got %b expected 0", f_valid2); end checks++;
        step(1);
        fetch_req = 1'b0;
        if ({f_valid2, f_data2} !== {1'b1, 32'h12345678}) begin errors++; $display("FAIL lf_word2: got %b/%h expected 1/12345678", f_valid2, f_data2); end checks++;
        step(1);
        if ({f_valid2, f_data2} !== {1'b1, 32'hAABBCCDD}) begin errors++; $display("FAIL lf_word3: got %b/%h expected 1/aabbccdd", f_valid2, f_data2); end checks++;
        step(1);
        if ({f_valid4, f_data4} !== {1'b1, 32'h12345678}) begin errors++; $display("FAIL lf_lat4: got %b/%h expected 1/12345678", f_valid4, f_data4); end checks++;
        step(4);
    endtask

    task automatic test_strobes;
        load_burst(32'hC, 1, 32'hFFFFFFFF, 32'h0, 32'h0, 4'hF);
        step(1);
        load_burst(32'hC, 1, 32'h00000000, 32'h0, 32'h0, 4'b0101);
        fetch_req = 1'b1; fetch_addr = 32'hC;
        step(1);
        fetch_req = 1'b0;
        step(1);
        if ({f_valid2, f_data2} !== {1'b1, 32'hFF00FF00}) begin errors++; $display("FAIL strb_data: got %b/%h expected 1/ff00ff00", f_valid2, f_data2); end checks++;
        step(4);
    endtask

    task automatic test_fetch_err;
        fetch_req = 1'b1; fetch_addr = 32'h6;
        step(1);
        fetch_addr = 32'h400;
        step(1);
        fetch_addr = 32'h8;
        if ({f_valid2, f_err2, f_data2} !== {2'b11, 32'h0}) begin errors++; $display("FAIL err_misaligned: got %b%b/%h expected 11/00000000", f_valid2, f_err2, f_data2); end checks++;
        step(1);
        fetch_addr = 32'hC;
        if ({f_valid2, f_err2, f_data2} !== {2'b11, 32'h0}) begin errors++; $display("FAIL err_range: got %b%b/%h expected 11/00000000", f_valid2, f_err2, f_data2); end checks++;
        step(1);
        fetch_req = 1'b0;
        if ({f_valid2, f_err2, f_data2} !== {2'b10, 32'h12345678}) begin errors++; $display("FAIL err_word2_kept: got %b%b/%h expected 10/12345678", f_valid2, f_err2, f_data2); end checks++;
        step(1);
        if ({f_valid2, f_err2, f_data2} !== {2'b10, 32'hFF00FF00}) begin errors++; $display("FAIL err_word3_kept: got %b%b/%h expected 10/ff00ff00", f_valid2, f_err2, f_data2); end checks++;
        step(4);
    endtask

    task automatic test_overflow;
        load_burst(32'h0, 1, 32'hCAFEF00D, 32'h0, 32'h0, 4'hF);
        step(1);
        load_burst(32'h3FC, 3, 32'h11111111, 32'h22222222, 32'h33333333, 4'hF);
        if (ld_ovf2 !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", ld_ovf2); end checks++;
        if (ld_cnt2 !== 9'd3) begin errors++; $display("FAIL ovf_count: got %0d expected 3", ld_cnt2); end checks++;
        fetch_req = 1'b1; fetch_addr = 32'h3FC;
        step(1);
        fetch_addr = 32'h0;
        step(1);
        fetch_req = 1'b0;
        if ({f_valid2, f_data2} !== {1'b1, 32'h11111111}) begin errors++; $display("FAIL ovf_word255: got %b/%h expected 1/11111111", f_valid2, f_data2); end checks++;
        step(1);
        if ({f_valid2, f_data2} !== {1'b1, 32'hCAFEF00D}) begin errors++; $display("FAIL ovf_no_wrap: got %b/%h expected 1/cafef00d", f_valid2, f_data2); end checks++;
        step(4);
    endtask

    task automatic test_drain;
        int nvalid;
        nvalid = 0;
        fetch_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fetch_addr = (i % 2 == 0) ? 32'h8 : 32'hC;
            step(1);
        end
        ld_start = 1'b1; ld_base = 32'h10; fetch_addr = 32'h0;
        #1;
        if ({f_ready2, f_ready4} !== 2'b00) begin errors++; $display("FAIL drain_refuse: got %b expected 00", {f_ready2, f_ready4}); end checks++;
        if (f_valid4 === 1'b1) nvalid++;
        step(1);
        ld_start = 1'b0; fetch_req = 1'b0;
        if (ld_ovf4 !== 1'b0) begin errors++; $display("FAIL drain_ovf_clear: got %b expected 0", ld_ovf4); end checks++;
        for (int k = 5; k < 8; k++) begin
            if ({ld_ready4, ld_busy4} !== 2'b01) begin errors++; $display("FAIL drain_hold_c%0d: got %b expected 01", k, {ld_ready4, ld_busy4}); end checks++;
            if (f_valid4 === 1'b1) nvalid++;
            step(1);
        end
        if (nvalid !== 4) begin errors++; $display("FAIL drain_valids: got %0d expected 4", nvalid); end checks++;
        if ({ld_ready4, f_valid4} !== 2'b10) begin errors++; $display("FAIL drain_exit: got %b expected 10", {ld_ready4, f_valid4}); end checks++;
        ld_valid = 1'b1; ld_data = 32'h5A5A5A5A; ld_strb = 4'hF; ld_last = 1'b1;
        step(1);
        ld_valid = 1'b0; ld_last = 1'b0;
        fetch_req = 1'b1; fetch_addr = 32'h10;
        step(1);
        fetch_req = 1'b0;
        step(3);
        if ({f_valid4, f_data4} !== {1'b1, 32'h5A5A5A5A}) begin errors++; $display("FAIL drain_load_data: got %b/%h expected 1/5a5a5a5a", f_valid4, f_data4); end checks++;
        step(4);
    endtask

    task automatic test_reset_mid_burst;
        ld_start = 1'b1; ld_base = 32'h20;
        step(1);
        ld_start = 1'b0; ld_valid = 1'b1; ld_data = 32'h0BADBEEF; ld_strb = 4'hF; ld_last = 1'b0;
        step(1);
        ld_valid = 1'b0;
        if (ld_cnt2 !== 9'd1) begin errors++; $display("FAIL mid_count: got %0d expected 1", ld_cnt2); end checks++;
        rst = 1'b0;
        #1;
        if ({ld_ready2, ld_busy2, ld_ready4, ld_busy4} !== 4'b0000) begin errors++; $display("FAIL mid_rst_flags: got %b expected 0000", {ld_ready2, ld_busy2, ld_ready4, ld_busy4}); end checks++;
        if (ld_cnt4 !== 9'd0) begin errors++; $display("FAIL mid_rst_count: got %0d expected 0", ld_cnt4); end checks++;
        step(1);
        rst = 1'b1;
        step(1);
        fetch_req = 1'b1; fetch_addr = 32'h20;
        #1;
        if (f_ready2 !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b expected 1", f_ready2); end checks++;
        step(1);
        fetch_req = 1'b0;
        step(1);
        if ({f_valid2, f_data2} !== {1'b1, 32'h0BADBEEF}) begin errors++; $display("FAIL mid_persist: got %b/%h expected 1/0badbeef", f_valid2, f_data2); end checks++;
        step(4);
    endtask

    initial begin
        test_reset();
        test_load_fetch();
        test_strobes();
        test_fetch_err();
        test_overflow();
        test_drain();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
